// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that lets one of NUM_REQ frame producers
// at a time write bytes into a shared UART TX FIFO. A grant lasts until the
// producer flags its last byte or goes silent for TIMEOUT cycles.
module uart_tx_arb #(
   parameter int          NUM_REQ = 4,
   parameter logic [11:0] THRESH  = 12'd2000,
   parameter logic [15:0] TIMEOUT = 16'd1000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     wen_in,
   input  logic [8*NUM_REQ-1:0]   wdata_in,
   input  logic [NUM_REQ-1:0]     done,
   output logic [NUM_REQ-1:0]     gnt,
   output logic                   tx_fifo_wen,
   output logic [7:0]             tx_fifo_wdata,
   input  logic                   tx_fifo_full,
   input  logic [11:0]            tx_fifo_usedw,
   output logic                   timeout_err,
   output logic [15:0]            drop_cnt
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t               r_state, w_nxt_state;
   logic [NUM_REQ-1:0]   r_gnt, w_nxt_gnt;
   logic [IW-1:0]        r_last, w_nxt_last;
   logic [IW-1:0]        w_gidx, w_rr_idx;
   logic                 w_rr_hit;
   logic [15:0]          r_idle_cnt, w_nxt_cnt;
   logic                 r_tout, w_nxt_tout;
   logic                 r_wen;
   logic [7:0]           r_wdata;
   logic [15:0]          r_drop;
   logic                 w_wen, w_done;
   logic [7:0]           w_gbyte;

   // Activity from the granted producer only; gnt is zero in IDLE, so every
   // producer strobe is masked there.
   assign w_wen   = |(wen_in & r_gnt);
   assign w_done  = |(done & r_gnt);
   assign w_gbyte = wdata_in[8*w_gidx +: 8];

   // Encode the one-hot grant into the index of the current grantee.
   always_comb begin
      w_gidx = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (r_gnt[k]) w_gidx = IW'(k);
   end

   // Round-robin pick: first requester after the last winner, wrapping.
   always_comb begin
      w_rr_idx = r_last;
      w_rr_hit = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!w_rr_hit && req[(int'(r_last) + i) % NUM_REQ]) begin
            w_rr_hit = 1'b1;
            w_rr_idx = IW'((int'(r_last) + i) % NUM_REQ);
         end
      end
   end

   // Next-state logic: grant, release on done, revoke on idle timeout.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_gnt   = r_gnt;
      w_nxt_last  = r_last;
      w_nxt_cnt   = r_idle_cnt;
      w_nxt_tout  = 1'b0;
      case (r_state)
         IDLE: begin
            // Counter held at zero so every grant starts a fresh idle window.
            w_nxt_cnt = '0;
            if (w_rr_hit && (tx_fifo_usedw < THRESH)) begin
               w_nxt_gnt           = '0;
               w_nxt_gnt[w_rr_idx] = 1'b1;
               w_nxt_state         = BUSY;
            end
         end
         BUSY: begin
            // Fill level is not looked at here: an open frame always finishes.
            if (w_done) begin
               w_nxt_gnt   = '0;
               w_nxt_last  = w_gidx;
               w_nxt_state = IDLE;
            end else if (w_wen) begin
               w_nxt_cnt = '0;
            end else if (r_idle_cnt == TIMEOUT - 16'd1) begin
               w_nxt_gnt   = '0;
               w_nxt_last  = w_gidx;
               w_nxt_tout  = 1'b1;
               w_nxt_state = IDLE;
            end else begin
               w_nxt_cnt = r_idle_cnt + 16'd1;
            end
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   // Arbiter state registers; last winner resets to the top index so
   // producer 0 is searched first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_last     <= IW'(NUM_REQ - 1);
         r_idle_cnt <= '0;
         r_tout     <= 1'b0;
      end else begin
         r_state    <= w_nxt_state;
         r_gnt      <= w_nxt_gnt;
         r_last     <= w_nxt_last;
         r_idle_cnt <= w_nxt_cnt;
         r_tout     <= w_nxt_tout;
      end
   end

   // FIFO write path: one-cycle forward, drop and count when FIFO is full.
   // Data follows every granted strobe (even dropped ones) and holds otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wen   <= 1'b0;
         r_wdata <= 8'h00;
         r_drop  <= 16'h0000;
      end else begin
         r_wen <= w_wen & ~tx_fifo_full;
         if (w_wen) r_wdata <= w_gbyte;
         if (w_wen && tx_fifo_full && (r_drop != 16'hFFFF))
            r_drop <= r_drop + 16'd1;
      end
   end

   assign gnt           = r_gnt;
   assign tx_fifo_wen   = r_wen;
   assign tx_fifo_wdata = r_wdata;
   assign timeout_err   = r_tout;
   assign drop_cnt      = r_drop;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed vector table plus hand sequences for the
// timeout and mid-frame reset corners of uart_tx_arb (TIMEOUT set to 8).
module tb_uart_tx_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req, wen_in, done, gnt;
   logic [31:0] wdata_in;
   logic        tx_fifo_wen, tx_fifo_full, timeout_err;
   logic [7:0]  tx_fifo_wdata;
   logic [11:0] tx_fifo_usedw;
   logic [15:0] drop_cnt;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      string       name;
      logic [3:0]  req, wen;
      logic [31:0] wd;
      logic [3:0]  dn;
      logic        full;
      logic [11:0] usedw;
      logic [3:0]  e_gnt;
      logic        e_wen;
      logic [7:0]  e_wd;
      logic [15:0] e_drop;
   } vec_t;

   vec_t vq[$];

   uart_tx_arb #(.NUM_REQ(4), .THRESH(12'd2000), .TIMEOUT(16'd8)) dut (
      .clk(clk), .rst(rst), .req(req), .wen_in(wen_in), .wdata_in(wdata_in),
      .done(done), .gnt(gnt), .tx_fifo_wen(tx_fifo_wen),
      .tx_fifo_wdata(tx_fifo_wdata), .tx_fifo_full(tx_fifo_full),
      .tx_fifo_usedw(tx_fifo_usedw), .timeout_err(timeout_err),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] g, input logic w,
                      input logic [7:0] d, input logic t, input logic [15:0] dc);
      n_vec++;
      if (gnt !== g || tx_fifo_wen !== w || tx_fifo_wdata !== d ||
          timeout_err !== t || drop_cnt !== dc) begin
         n_err++;
         $display("FAIL %s: got gnt=%b wen=%b wdata=%h tout=%b drop=%0d, want gnt=%b wen=%b wdata=%h tout=%b drop=%0d",
                  nm, gnt, tx_fifo_wen, tx_fifo_wdata, timeout_err, drop_cnt,
                  g, w, d, t, dc);
      end
   endtask

   task automatic add(input string nm, input logic [3:0] rq, input logic [3:0] we,
                      input logic [31:0] wd, input logic [3:0] dn, input logic fl,
                      input logic [11:0] uw, input logic [3:0] eg, input logic ew,
                      input logic [7:0] ed, input logic [15:0] edc);
      vec_t v;
      v.name = nm; v.req = rq; v.wen = we; v.wd = wd; v.dn = dn; v.full = fl;
      v.usedw = uw; v.e_gnt = eg; v.e_wen = ew; v.e_wd = ed; v.e_drop = edc;
      vq.push_back(v);
   endtask

   initial begin
      logic [7:0] b;
      rst = 1'b1; req = '0; wen_in = '0; wdata_in = '0; done = '0;
      tx_fifo_full = 1'b0; tx_fifo_usedw = '0;

      // Round robin from reset: 0,1,2,3, req ignored while busy, one idle gap.
      for (int k = 0; k < 4; k++) begin
         add("rr_grant", 4'hF, 4'h0, 32'h0, 4'h0, 1'b0, 12'd0, 4'(1 << k), 1'b0, 8'h00, 16'd0);
         add("rr_hold", 4'hF, 4'h0, 32'h0, 4'(1 << ((k + 1) % 4)), 1'b0, 12'd0, 4'(1 << k), 1'b0, 8'h00, 16'd0);
         add("rr_release", 4'hF, 4'h0, 32'h0, 4'(1 << k), 1'b0, 12'd0, 4'h0, 1'b0, 8'h00, 16'd0);
      end
      // Single frame from producer 2 with non-granted noise on producer 0.
      add("single_grant", 4'b0100, 4'h0, 32'h0, 4'h0, 1'b0, 12'd0, 4'b0100, 1'b0, 8'h00, 16'd0);
      for (int i = 0; i < 8; i++) begin
         b = 8'h11 + 8'(i);
         add("single_byte", 4'h0, 4'b0101, (32'(b) << 16) | 32'hAA,
             (i == 7) ? 4'b0100 : 4'b0001, 1'b0, 12'd0,
             (i == 7) ? 4'h0 : 4'b0100, 1'b1, b, 16'd0);
         if (i < 7)
            add("single_gap", 4'h0, 4'b0001, 32'hBB, 4'h0, 1'b0, 12'd0, 4'b0100, 1'b0, b, 16'd0);
      end
      add("single_idle", 4'h0, 4'h0, 32'h0, 4'h0, 1'b0, 12'd0, 4'h0, 1'b0, 8'h18, 16'd0);
      // Threshold gating in IDLE, no revoke in BUSY.
      add("thr_block", 4'b0001, 4'h0, 32'h0, 4'h0, 1'b0, 12'd2000, 4'h0, 1'b0, 8'h18, 16'd0);
      add("thr_block2", 4'b0001, 4'h0, 32'h0, 4'h0, 1'b0, 12'd2000, 4'h0, 1'b0, 8'h18, 16'd0);
      add("thr_open", 4'b0001, 4'h0, 32'h0, 4'h0, 1'b0, 12'd1999, 4'b0001, 1'b0, 8'h18, 16'd0);
      add("thr_busy", 4'h0, 4'h0, 32'h0, 4'h0, 1'b0, 12'd2000, 4'b0001, 1'b0, 8'h18, 16'd0);
      add("thr_done", 4'h0, 4'h0, 32'h0, 4'b0001, 1'b0, 12'd2000, 4'h0, 1'b0, 8'h18, 16'd0);
      add("thr_max", 4'b0001, 4'h0, 32'h0, 4'h0, 1'b0, 12'hFFF, 4'h0, 1'b0, 8'h18, 16'd0);
      // FIFO full drops for producer 1.
      add("full_grant", 4'b0010, 4'h0, 32'h0, 4'h0, 1'b0, 12'd0, 4'b0010, 1'b0, 8'h18, 16'd0);
      add("full_drop1", 4'h0, 4'b0010, 32'h5500, 4'h0, 1'b1, 12'd0, 4'b0010, 1'b0, 8'h55, 16'd1);
      add("full_drop2", 4'h0, 4'b0010, 32'h6600, 4'h0, 1'b1, 12'd0, 4'b0010, 1'b0, 8'h66, 16'd2);
      add("full_drop3", 4'h0, 4'b0010, 32'h7700, 4'h0, 1'b1, 12'd0, 4'b0010, 1'b0, 8'h77, 16'd3);
      add("full_last", 4'h0, 4'b0010, 32'h8800, 4'b0010, 1'b0, 12'd0, 4'h0, 1'b1, 8'h88, 16'd3);
      add("full_idle", 4'h0, 4'h0, 32'h0, 4'h0, 1'b0, 12'd0, 4'h0, 1'b0, 8'h88, 16'd3);

      #3;
      chk("reset_state", 4'h0, 1'b0, 8'h00, 1'b0, 16'd0);
      tick();
      rst = 1'b0;

      foreach (vq[i]) begin
         req = vq[i].req; wen_in = vq[i].wen; wdata_in = vq[i].wd; done = vq[i].dn;
         tx_fifo_full = vq[i].full; tx_fifo_usedw = vq[i].usedw;
         tick();
         chk(vq[i].name, vq[i].e_gnt, vq[i].e_wen, vq[i].e_wd, 1'b0, vq[i].e_drop);
      end
      req = '0; wen_in = '0; wdata_in = '0; done = '0; tx_fifo_full = 1'b0; tx_fifo_usedw = '0;

      // Silent grantee: revoked 8 edges after the grant, one-cycle pulse.
      req = 4'b0001; tick(); req = '0;
      chk("to_grant", 4'b0001, 1'b0, 8'h88, 1'b0, 16'd3);
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i < 8) chk("to_wait", 4'b0001, 1'b0, 8'h88, 1'b0, 16'd3);
         else       chk("to_fire", 4'h0, 1'b0, 8'h88, 1'b1, 16'd3);
      end
      tick();
      chk("to_pulse_end", 4'h0, 1'b0, 8'h88, 1'b0, 16'd3);

      // done in the timeout cycle wins: normal release, no pulse.
      req = 4'b0010; tick(); req = '0;
      chk("tod_grant", 4'b0010, 1'b0, 8'h88, 1'b0, 16'd3);
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("tod_wait", 4'b0010, 1'b0, 8'h88, 1'b0, 16'd3);
      end
      done = 4'b0010; tick(); done = '0;
      chk("tod_release", 4'h0, 1'b0, 8'h88, 1'b0, 16'd3);
      tick();
      chk("tod_quiet", 4'h0, 1'b0, 8'h88, 1'b0, 16'd3);

      // A forwarded byte restarts the idle window.
      req = 4'b0100; tick(); req = '0;
      chk("tob_grant", 4'b0100, 1'b0, 8'h88, 1'b0, 16'd3);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("tob_wait", 4'b0100, 1'b0, 8'h88, 1'b0, 16'd3);
      end
      wen_in = 4'b0100; wdata_in = 32'h0099_0000; tick(); wen_in = '0;
      chk("tob_byte", 4'b0100, 1'b1, 8'h99, 1'b0, 16'd3);
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("tob_wait2", 4'b0100, 1'b0, 8'h99, 1'b0, 16'd3);
      end
      tick();
      chk("tob_fire", 4'h0, 1'b0, 8'h99, 1'b1, 16'd3);

      // Reset mid-frame after 4 bytes from producer 3.
      req = 4'b1000; tick(); req = '0;
      chk("rst_grant", 4'b1000, 1'b0, 8'h99, 1'b0, 16'd3);
      for (int i = 0; i < 4; i++) begin
         b = 8'h21 + 8'(i);
         wen_in = 4'b1000; wdata_in = 32'(b) << 24; tick();
         chk("rst_byte", 4'b1000, 1'b1, b, 1'b0, 16'd3);
      end
      wen_in = 4'b1000; wdata_in = 32'h2500_0000;
      #2 rst = 1'b1;
      #1 chk("rst_async", 4'h0, 1'b0, 8'h00, 1'b0, 16'd0);
      tick();
      chk("rst_hold", 4'h0, 1'b0, 8'h00, 1'b0, 16'd0);
      rst = 1'b0; wen_in = '0; wdata_in = '0; req = 4'hF;
      tick();
      chk("rst_first_p0", 4'b0001, 1'b0, 8'h00, 1'b0, 16'd0);
      req = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of frame producers that share one UART TX FIFO; it is fixed at 4 in this revision.
REQ-002 Parameter THRESH, default 12'd2000, SHALL set the FIFO fill level at or above which no new grant is issued.
REQ-003 Parameter TIMEOUT, default 16'd1000, SHALL set the number of idle grant cycles after which a grant is revoked.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 req  input  4  SHALL carry one frame request per producer, held high until granted.
REQ-007 wen_in  input  4  SHALL carry one byte-write strobe per producer.
REQ-008 wdata_in  input  32  SHALL carry one byte per producer; producer k uses bits [8k+7:8k].
REQ-009 done  input  4  SHALL be the per-producer last-byte flag, valid with or without that producer's wen_in.
REQ-010 gnt  output  4  SHALL be the one-hot (or zero) grant, registered.
REQ-011 tx_fifo_wen  output  1  SHALL be the registered FIFO write strobe.
REQ-012 tx_fifo_wdata  output  8  SHALL be the registered FIFO write data.
REQ-013 tx_fifo_full  input  1  SHALL be the FIFO full flag.
REQ-014 tx_fifo_usedw  input  12  SHALL be the FIFO fill level.
REQ-015 timeout_err  output  1  SHALL be a one-cycle pulse when a grant is revoked by timeout.
REQ-016 drop_cnt  output  16  SHALL count bytes dropped because the FIFO was full; it saturates at 16'hFFFF.

Function
REQ-017 The block SHALL implement a two-state FSM, IDLE and BUSY.
REQ-018 In IDLE, when req!=0 and tx_fifo_usedw<THRESH, the block SHALL, on the next edge, set gnt to the round-robin winner and enter BUSY.
- Search starts at last_winner+1 and wraps from 3 to 0.
REQ-019 In IDLE with tx_fifo_usedw>=THRESH, gnt SHALL stay 0 regardless of req.
REQ-020 In BUSY, gnt SHALL stay constant; req changes SHALL be ignored.
REQ-021 In BUSY, done[g]=1 from the granted producer g SHALL clear gnt, set last_winner=g and return to IDLE on the next edge.
REQ-022 A byte written in the same cycle as done[g] SHALL still be forwarded.
REQ-023 After every grant release (done or timeout), the block SHALL spend at least one cycle in IDLE with gnt=0 before the next grant.
REQ-024 Forwarding SHALL have one-cycle latency.
- tx_fifo_wen <= wen_in[g] & gnt[g] & !tx_fifo_full.
- tx_fifo_wdata <= wdata_in byte g whenever wen_in[g] & gnt[g]; otherwise it holds its value.
REQ-025 wen_in and done from non-granted producers, and all inputs while in IDLE, SHALL be ignored.
REQ-026 When wen_in[g] & gnt[g] & tx_fifo_full, the byte SHALL be dropped and drop_cnt SHALL increment by 1, saturating.
REQ-027 The idle counter (16 bits) SHALL be cleared on grant and on every forwarded or dropped byte from the granted producer; it SHALL increment each other BUSY cycle.
REQ-028 When the idle counter reaches TIMEOUT-1 in BUSY, the block SHALL on the next edge clear gnt, pulse timeout_err for one cycle, set last_winner=g and enter IDLE.
REQ-029 If done[g] and the timeout condition occur in the same cycle, done SHALL take priority: no timeout_err, normal release.
REQ-030 A tx_fifo_usedw rise to THRESH during BUSY SHALL NOT revoke the grant; the current frame completes.

Reset
REQ-031 rst=1 SHALL immediately (asynchronously) force the following values:
- FSM = IDLE, gnt = 0, last_winner = 3 (producer 0 wins first);
- tx_fifo_wen = 0, tx_fifo_wdata = 8'h00;
- timeout_err = 0, drop_cnt = 0, idle counter = 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame without emitting any further tx_fifo_wen.

Verification
REQ-033 Single request: req=4'b0100 with usedw=0 -> gnt=4'b0100 one edge later; 8 bytes 0x11..0x18 appear on tx_fifo_wdata one cycle after each wen_in[2]; done -> gnt=0 the next cycle.
REQ-034 Round-robin: req=4'b1111 held through 4 frames -> grant order 0,1,2,3, each separated by exactly one gnt=0 cycle.
REQ-035 Threshold: usedw=2000 with req=4'b0001 -> gnt stays 0; usedw drops to 1999 -> gnt=4'b0001 on the next edge.
REQ-036 Full: 3 bytes written while tx_fifo_full=1 -> tx_fifo_wen stays 0 and drop_cnt=3.
REQ-037 Timeout: grantee silent with TIMEOUT=8 -> gnt clears and timeout_err pulses exactly once, 8 cycles after the grant; done and timeout in the same cycle -> no timeout_err.
REQ-038 Reset mid-frame after 4 of 8 bytes -> gnt=0, tx_fifo_wen=0 and drop_cnt=0 immediately; after release, req=4'b1111 -> producer 0 is granted first.
